cpu_control: RTL and testbench
==============================

Name: cpu_control

Overview:
- Multicycle control FSM that sequences the RV32I datapath (IR, MAR, MDR, PC, regfile, ALU, CMP, store-data register).
- Decodes the datapath's opcode, funct3, funct7, br_en and addr_2bit outputs, and drives every load enable, mux select, ALU/CMP op and the memory handshake.
- Sits beside the datapath inside the CPU top; memory-side signals go to the cache/arbiter.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_resp before giving up and returning to FETCH1; 0 = wait forever.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- opcode  in  7  IR opcode field.
- funct3  in  3  IR funct3.
- funct7  in  7  IR funct7; only bit 5 is used.
- br_en  in  1  CMP result.
- addr_2bit  in  2  MAR[1:0].
- mem_resp  in  1  memory done, one-cycle pulse.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  datapath register enables.
- pcmux_sel  out  2  0 = pc+4, 1 = alu_out, 2 = alu_mod2.
- alumux1_sel  out  1  0 = rs1, 1 = pc.
- alumux2_sel  out  3  0 = i, 1 = u, 2 = b, 3 = s, 4 = j, 5 = rs2.
- regfilemux_sel  out  4  0 = alu, 1 = br_en, 2 = u_imm, 3 = lw, 4 = pc+4, 5 = lb, 6 = lbu, 7 = lh, 8 = lhu.
- marmux_sel  out  1  0 = pc, 1 = alu.
- cmpmux_sel  out  1  0 = rs2, 1 = i_imm.
- aluop  out  3  add 0, sll 1, sra 2, sub 3, xor 4, srl 5, or 6, and 7.
- cmpop  out  3  branch funct3 encoding.
- mem_read, mem_write  out  1  memory requests.
- mem_byte_enable  out  4  store byte mask.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to FETCH1 and the timeout counter clears.
  - While rst is low, all load_* signals, mem_read, mem_write and the cycle outputs are forced to 0.
  - All selects read 0, aluop = add, mem_byte_enable = 4'b1111.
- Default outputs: every state starts from the reset defaults above, and each state overrides only what it needs. Outputs are Moore (decoded from state plus the registered IR fields).
- Fetch and decode states:
  - FETCH1: load_mar = 1, marmux = pc. Next state FETCH2.
  - FETCH2: mem_read = 1, load_mdr = 1. Stay until mem_resp, then go to FETCH3.
  - FETCH3: load_ir = 1. Next state DECODE.
  - DECODE: no loads. Branch on opcode.
    - OP-IMM goes to IMM; OP goes to REG; LUI, AUIPC, BRANCH, JAL and JALR go to their own states.
    - LOAD and STORE go to CALC_ADDR.
    - Any other opcode goes to FETCH1 with no architectural write (PC not advanced; the bench flags it).
- Execute states (each of these returns to FETCH1 and asserts load_pc with pcmux = pc+4 unless stated otherwise):
  - IMM: load_regfile = 1, alumux1 = rs1, alumux2 = i.
    - funct3 2 (slti) and 3 (sltiu): cmpmux = i_imm, cmpop = blt / bltu, regfilemux = br_en.
    - funct3 5: aluop = sra if funct7[5], else srl.
    - Otherwise aluop follows funct3: add 0, sll 1, xor 4, or 6, and 7.
  - REG: as IMM but alumux2 = rs2 and cmpmux = rs2. funct3 0 with funct7[5] selects sub.
  - LUI: regfilemux = u_imm, load_regfile = 1.
  - AUIPC: alumux1 = pc, alumux2 = u, aluop = add, regfilemux = alu, load_regfile = 1.
  - BR: cmpop = funct3, cmpmux = rs2, alumux1 = pc, alumux2 = b, load_pc = 1. pcmux = alu_out if br_en, else pc+4.
  - JAL: regfilemux = pc+4, load_regfile = 1, alumux1 = pc, alumux2 = j, pcmux = alu_out, load_pc = 1.
  - JALR: as JAL but alumux1 = rs1, alumux2 = i, pcmux = alu_mod2.
- Load and store states:
  - CALC_ADDR: alumux1 = rs1, alumux2 = i (load) or s (store), aluop = add, marmux = alu, load_mar = 1. For stores also load_data_out = 1. Next state LD1 or ST1.
  - LD1: mem_read = 1, load_mdr = 1. Hold until mem_resp, then go to LD2.
  - LD2: regfilemux from funct3 (0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu), load_regfile = 1, pc+4 load. Next state FETCH1.
  - ST1: mem_write = 1. Byte enable:
    - sw: 4'b1111.
    - sh: 4'b0011 << addr_2bit.
    - sb: 4'b0001 << addr_2bit.
    - Hold until mem_resp, then go to ST2.
  - ST2: pc+4 load. Next state FETCH1.
- Memory handshake and timeout:
  - mem_read and mem_write stay high and stable every cycle until the mem_resp cycle, inclusive. They drop the next cycle.
  - mem_resp outside FETCH2, LD1 or ST1 is ignored.
  - The counter clears on entry to each memory state.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT with no mem_resp, go to FETCH1 with no register loads.
- Boundaries:
  - sh with addr_2bit = 3 produces mask 4'b1000 (the shift truncates); this is a misaligned access and is not trapped.
  - Reset during a memory state drops mem_read and mem_write immediately (asynchronously). No partial load_regfile or load_pc occurs.
- Latency: IMM, REG, LUI, AUIPC, BR, JAL and JALR take 5 cycles plus fetch wait. Loads and stores take 7 cycles plus two memory waits.

Test Plan:
- addi x1, x0, 5 with mem_resp returned 1 cycle after request → state sequence FETCH1, FETCH2, FETCH2, FETCH3, DECODE, IMM; in IMM load_regfile = 1, aluop = 0, alumux2 = 0, load_pc = 1 with pcmux = 0.
- beq with br_en = 1, then again with br_en = 0 → in BR, pcmux = 1 then 0; load_regfile stays 0 throughout.
- sb with addr_2bit = 2'b10 → mem_byte_enable = 4'b0100; mem_write held 3 cycles until mem_resp, then drops; ST2 asserts load_pc.
- lhu with a 4-cycle memory delay → load_mdr high for all 4 LD1 cycles; LD2 regfilemux = 8, load_regfile = 1.
- rst pulled low for 1 cycle mid-LD1 → mem_read falls to 0 asynchronously; after release the state is FETCH1 with load_mar = 1 and no regfile write.
- Opcode 7'b0000000 → DECODE goes to FETCH1; no load_pc, load_regfile or mem_write asserted.

Source files
------------

// File: rtl/cpu_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute and memory
// phases, and drives the datapath enables, mux selects and memory handshake.
module cpu_control #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] addr_2bit,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SRA  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2
  } state_e;

  state_e      state_q;
  logic [31:0] tmo_cnt_q;
  logic        mem_timeout;

  assign mem_timeout = (MEM_TIMEOUT != 0) && (tmo_cnt_q >= MEM_TIMEOUT - 32'd1);

  // The wait counter only advances while a memory state is stalled, so every
  // transition (including entry into a memory state) leaves it cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH1;
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= '0;
      case (state_q)
        S_FETCH1: state_q <= S_FETCH2;
        S_FETCH2: begin
          if (mem_resp)         state_q <= S_FETCH3;
          else if (mem_timeout) state_q <= S_FETCH1;
          else                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
        S_FETCH3: state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_IMM:   state_q <= S_IMM;
            OP_REG:   state_q <= S_REG;
            OP_LUI:   state_q <= S_LUI;
            OP_AUIPC: state_q <= S_AUIPC;
            OP_BR:    state_q <= S_BR;
            OP_JAL:   state_q <= S_JAL;
            OP_JALR:  state_q <= S_JALR;
            OP_LOAD,
            OP_STORE: state_q <= S_CALC_ADDR;
            default:  state_q <= S_FETCH1;
          endcase
        end
        S_CALC_ADDR: state_q <= (opcode == OP_STORE) ? S_ST1 : S_LD1;
        S_LD1: begin
          if (mem_resp)         state_q <= S_LD2;
          else if (mem_timeout) state_q <= S_FETCH1;
          else                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
        S_ST1: begin
          if (mem_resp)         state_q <= S_ST2;
          else if (mem_timeout) state_q <= S_FETCH1;
          else                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
        default: state_q <= S_FETCH1;
      endcase
    end
  end

  // Outputs are decoded from the state and the datapath's IR fields; gating
  // with rst makes them fall to the idle values as soon as reset asserts.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = 2'd0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = 3'd0;
    regfilemux_sel  = 4'd0;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    aluop           = ALU_ADD;
    cmpop           = 3'd0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    if (rst) begin
      case (state_q)
        S_FETCH1: load_mar = 1'b1;
        S_FETCH2, S_LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
        end
        S_FETCH3: load_ir = 1'b1;
        S_IMM, S_REG: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          if (state_q == S_REG) alumux2_sel = 3'd5;
          case (funct3)
            3'd2, 3'd3: begin
              cmpmux_sel     = (state_q == S_IMM);
              cmpop          = (funct3 == 3'd2) ? CMP_BLT : CMP_BLTU;
              regfilemux_sel = 4'd1;
            end
            3'd0:    aluop = (state_q == S_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'd5:    aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            default: aluop = funct3;
          endcase
        end
        S_LUI: begin
          regfilemux_sel = 4'd2;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_AUIPC: begin
          alumux1_sel  = 1'b1;
          alumux2_sel  = 3'd1;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
        end
        S_BR: begin
          cmpop       = funct3;
          alumux1_sel = 1'b1;
          alumux2_sel = 3'd2;
          load_pc     = 1'b1;
          pcmux_sel   = br_en ? 2'd1 : 2'd0;
        end
        S_JAL: begin
          regfilemux_sel = 4'd4;
          load_regfile   = 1'b1;
          alumux1_sel    = 1'b1;
          alumux2_sel    = 3'd4;
          pcmux_sel      = 2'd1;
          load_pc        = 1'b1;
        end
        S_JALR: begin
          regfilemux_sel = 4'd4;
          load_regfile   = 1'b1;
          pcmux_sel      = 2'd2;
          load_pc        = 1'b1;
        end
        S_CALC_ADDR: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          if (opcode == OP_STORE) begin
            alumux2_sel   = 3'd3;
            load_data_out = 1'b1;
          end
        end
        S_LD2: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (funct3)
            3'd0:    regfilemux_sel = 4'd5;
            3'd1:    regfilemux_sel = 4'd7;
            3'd4:    regfilemux_sel = 4'd6;
            3'd5:    regfilemux_sel = 4'd8;
            default: regfilemux_sel = 4'd3;
          endcase
        end
        S_ST1: begin
          mem_write = 1'b1;
          case (funct3)
            3'd0:    mem_byte_enable = 4'b0001 << addr_2bit;
            3'd1:    mem_byte_enable = 4'b0011 << addr_2bit;
            default: mem_byte_enable = 4'b1111;
          endcase
        end
        S_ST2: load_pc = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Randomised scoreboard bench for cpu_control: the bench plays datapath and
// memory, predicts every cycle's control word from the instruction semantics.
module tb_cpu_control;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux;
    logic       alumux1;
    logic [2:0] alumux2;
    logic [3:0] regfilemux;
    logic       marmux, cmpmux;
    logic [2:0] aluop, cmpop;
    logic       mem_read, mem_write;
    logic [3:0] mbe;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic resp;
  } cyc_t;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OPREG = 7'b0110011;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic br_en, mem_resp;
  logic [1:0] addr_2bit;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel;
  logic alumux1_sel, marmux_sel, cmpmux_sel, mem_read, mem_write;
  logic [2:0] alumux2_sel, aluop, cmpop;
  logic [3:0] regfilemux_sel, mem_byte_enable;

  always #5 clk = ~clk;

  cpu_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_2bit(addr_2bit), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable)
  );

  ctl_t act;
  assign act = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
                cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable};

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   noise  = 1'b0;
  ctl_t expq[$];
  cyc_t plan[$];

  task automatic chk(string name, ctl_t a, ctl_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin : monitor
    ctl_t e;
    if (mon_en) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow cycle %0d: got empty expected entry", cyc);
      end else begin
        e = expq.pop_front();
        chk("ctl_word", act, e);
      end
      cyc++;
    end
  end

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.mbe = 4'b1111;
    return c;
  endfunction

  task automatic add(ctl_t c);
    cyc_t e;
    e.exp  = c;
    e.resp = noise && ($urandom_range(0, 3) == 0);
    plan.push_back(e);
  endtask

  // A memory wait of n cycles: request held throughout, response on the last.
  task automatic add_wait(ctl_t c, int n);
    cyc_t e;
    for (int k = 0; k < n; k++) begin
      e.exp  = c;
      e.resp = (k == n - 1);
      plan.push_back(e);
    end
  endtask

  task automatic build(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic br,
                       logic [1:0] a, int fd, int md);
    ctl_t c;
    plan.delete();
    c = idle(); c.load_mar = 1; add(c);
    c = idle(); c.mem_read = 1; c.load_mdr = 1; add_wait(c, fd);
    c = idle(); c.load_ir = 1; add(c);
    add(idle());
    c = idle();
    c.load_pc = 1;
    case (op)
      OPIMM, OPREG: begin
        c.load_regfile = 1;
        c.alumux2 = (op == OPREG) ? 3'd5 : 3'd0;
        case (f3)
          3'd0: c.aluop = (op == OPREG && f7[5]) ? 3'd3 : 3'd0;
          3'd1: c.aluop = 3'd1;
          3'd2: begin c.cmpop = 3'd4; c.cmpmux = (op == OPIMM); c.regfilemux = 4'd1; end
          3'd3: begin c.cmpop = 3'd6; c.cmpmux = (op == OPIMM); c.regfilemux = 4'd1; end
          3'd4: c.aluop = 3'd4;
          3'd5: c.aluop = f7[5] ? 3'd2 : 3'd5;
          3'd6: c.aluop = 3'd6;
          default: c.aluop = 3'd7;
        endcase
        add(c);
      end
      LUI: begin c.load_regfile = 1; c.regfilemux = 4'd2; add(c); end
      AUIPC: begin c.load_regfile = 1; c.alumux1 = 1; c.alumux2 = 3'd1; add(c); end
      BR: begin
        c.cmpop = f3; c.alumux1 = 1; c.alumux2 = 3'd2; c.pcmux = br ? 2'd1 : 2'd0;
        add(c);
      end
      JAL: begin
        c.load_regfile = 1; c.regfilemux = 4'd4; c.alumux1 = 1; c.alumux2 = 3'd4;
        c.pcmux = 2'd1; add(c);
      end
      JALR: begin c.load_regfile = 1; c.regfilemux = 4'd4; c.pcmux = 2'd2; add(c); end
      LOAD: begin
        c = idle(); c.marmux = 1; c.load_mar = 1; add(c);
        c = idle(); c.mem_read = 1; c.load_mdr = 1; add_wait(c, md);
        c = idle(); c.load_regfile = 1; c.load_pc = 1;
        case (f3)
          3'd0: c.regfilemux = 4'd5;
          3'd1: c.regfilemux = 4'd7;
          3'd4: c.regfilemux = 4'd6;
          3'd5: c.regfilemux = 4'd8;
          default: c.regfilemux = 4'd3;
        endcase
        add(c);
      end
      STORE: begin
        c = idle(); c.marmux = 1; c.load_mar = 1; c.alumux2 = 3'd3; c.load_data_out = 1;
        add(c);
        c = idle(); c.mem_write = 1;
        if (f3 == 3'd0)      c.mbe = 4'(1 << a);
        else if (f3 == 3'd1) c.mbe = 4'(3 << a);
        add_wait(c, md);
        c = idle(); c.load_pc = 1; add(c);
      end
      default: ;
    endcase
  endtask

  // Drives one planned instruction; stop >= 0 returns mid-cycle at that index.
  task automatic run(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic br,
                     logic [1:0] a, int fd, int md, int stop);
    opcode = op; funct3 = f3; funct7 = f7; br_en = br; addr_2bit = a;
    build(op, f3, f7, br, a, fd, md);
    $display("instr op=%b f3=%0d f7b5=%0d br=%0d a=%0d fd=%0d md=%0d cycles=%0d",
             op, f3, f7[5], br, a, fd, md, plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      mem_resp = plan[i].resp;
      expq.push_back(plan[i].exp);
      if (i == stop) begin
        @(negedge clk);
        #2;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] ops [12] = '{OPIMM, OPREG, LUI, AUIPC, BR, JAL, JALR, LOAD, STORE,
                           7'b0000000, 7'b1111111, 7'b0001111};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    rst = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; br_en = 0; addr_2bit = 0; mem_resp = 0;
    #3;
    chk("reset_outputs", act, idle());
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    run(OPIMM, 3'd0, 7'd0, 0, 2'd0, 2, 1, -1);
    run(BR,    3'd0, 7'd0, 1, 2'd0, 1, 1, -1);
    run(BR,    3'd0, 7'd0, 0, 2'd0, 1, 1, -1);
    run(STORE, 3'd0, 7'd0, 0, 2'd2, 1, 3, -1);
    run(STORE, 3'd1, 7'd0, 0, 2'd3, 1, 1, -1);
    run(LOAD,  3'd5, 7'd0, 0, 2'd0, 1, 4, -1);
    run(OPREG, 3'd0, 7'b0100000, 0, 2'd0, 1, 1, -1);

    // Reset asserted during the second LD1 cycle, held across one rising edge.
    run(LOAD, 3'd2, 7'd0, 0, 2'd0, 1, 4, 6);
    rst = 1'b0;
    mem_resp = 1'b0;
    #1;
    chk("async_reset_mid_ld1", act, idle());
    @(posedge clk);
    #1;
    rst = 1'b1;

    run(7'b0000000, 3'd0, 7'd0, 0, 2'd0, 1, 1, -1);

    noise = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 11)];
      f3 = 3'($urandom_range(0, 7));
      if (op == LOAD)  f3 = ld_f3[$urandom_range(0, 4)];
      if (op == STORE) f3 = 3'($urandom_range(0, 2));
      if (op == BR)    f3 = br_f3[$urandom_range(0, 5)];
      run(op, f3, ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000,
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom_range(1, 4), $urandom_range(1, 4), -1);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
